fifo_rd_drain: RTL

//  Read-side consumer for fifo_asy: runs in the read clock domain, pulls words via rd_en/rdata/rdata_valid,

---
 rtl/fifo_rd_drain_pkg.sv | 19 +
 rtl/fifo_rd_drain_if.sv | 22 ++
 rtl/fifo_rd_drain_skid2.sv | 64 ++++++
 rtl/fifo_rd_drain.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fifo_rd_drain_pkg.sv
// Shared types and constants for the fifo_asy read-side drain: FSM encoding, skid depth, credit rule.
package fifo_rd_drain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } drain_state_e;

    localparam int SKID_DEPTH = 2;

    typedef logic [1:0] occ_t;

    // A new read may be issued only if every word already owed to us still fits in the skid buffer.
    function automatic logic credit_avail(input occ_t occ, input logic inflight);
        return ({1'b0, occ} + {2'b00, inflight}) < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_rd_drain_if.sv
// FIFO read bus plus downstream valid/ready stream seen by the drain block.
interface fifo_rd_drain_if #(
    parameter int wd = 4
);
    logic          empty;
    logic          rd_en;
    logic [wd-1:0] rdata;
    logic          rdata_valid;
    logic          out_valid;
    logic          out_ready;
    logic [wd-1:0] out_data;

    modport master (
        input  empty, rdata, rdata_valid, out_ready,
        output rd_en, out_valid, out_data
    );

    modport slave (
        output empty, rdata, rdata_valid, out_ready,
        input  rd_en, out_valid, out_data
    );
endinterface

// File: rtl/fifo_rd_drain_skid2.sv
// Two-entry in-order push/pop buffer; entry 0 is always the head presented downstream.
module fifo_rd_drain_skid2
    import fifo_rd_drain_pkg::*;
#(
    parameter int wd = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [wd-1:0] din_i,
    input  logic          pop_i,
    output logic [wd-1:0] dout_o,
    output occ_t          occ_o,
    output logic          ovf_o
);

    logic [1:0][wd-1:0] mem_q, mem_d;
    occ_t               occ_q, occ_d;
    logic               pop_eff;
    logic               push_eff;

    always_comb begin
        mem_d    = mem_q;
        occ_d    = occ_q;
        pop_eff  = pop_i && (occ_q != 2'd0);
        // A full buffer can still take a word on the same edge it releases one.
        push_eff = push_i && ((occ_q != 2'(SKID_DEPTH)) || pop_eff);
        ovf_o    = push_i && !push_eff;
        case ({push_eff, pop_eff})
            2'b10: begin
                if (occ_q == 2'd0) mem_d[0] = din_i;
                else               mem_d[1] = din_i;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) mem_d[0] = mem_q[1];
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    mem_d[0] = din_i;
                end else begin
                    mem_d[0] = mem_q[1];
                    mem_d[1] = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            occ_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign dout_o = mem_q[0];
    assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain consumer for fifo_asy: credit-limited reads into a 2-deep skid buffer, stream output,
// incrementing-pattern checker, capture counter and sticky protocol error.
//
//  state | meaning
//  IDLE  | not reading: enable low or FIFO empty
//  RUN   | issuing reads, credit available
//  STALL | skid buffer plus in-flight word fill the credit, waiting for a pop
module fifo_rd_drain
    import fifo_rd_drain_pkg::*;
#(
    parameter int wd    = 4,
    parameter int cnt_w = 16
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             enable_i,
    fifo_rd_drain_if.master  bus,
    output logic [cnt_w-1:0] word_cnt_o,
    output logic             seq_err_o,
    output logic             proto_err_o
);

    drain_state_e     state_q;
    logic             inflight_q, inflight_d;
    logic             first_q, first_d;
    logic [wd-1:0]    expect_q, expect_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic             seq_err_q, seq_err_d;
    logic             proto_err_q, proto_err_d;

    occ_t             occ;
    logic             ovf;
    logic             credit;
    logic             rd_en;
    logic             pop;

    assign credit = credit_avail(occ, inflight_q);
    // Gated by rst so no read is accepted while the block is held in reset.
    assign rd_en  = !rst && enable_i && !bus.empty && credit;
    assign pop    = bus.out_valid && bus.out_ready;

    assign bus.rd_en     = rd_en;
    assign bus.out_valid = (occ != 2'd0);

    fifo_rd_drain_skid2 #(.wd(wd)) u_skid (
        .clk    (rclk),
        .rst    (rst),
        .push_i (bus.rdata_valid),
        .din_i  (bus.rdata),
        .pop_i  (pop),
        .dout_o (bus.out_data),
        .occ_o  (occ),
        .ovf_o  (ovf)
    );

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rd_en) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable_i || bus.empty) state_q <= ST_IDLE;
                    else if (!credit)           state_q <= ST_STALL;
                end
                ST_STALL: begin
                    if (!enable_i || bus.empty) state_q <= ST_IDLE;
                    else if (credit)            state_q <= ST_RUN;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        inflight_d  = inflight_q;
        first_d     = first_q;
        expect_d    = expect_q;
        cnt_d       = cnt_q;
        seq_err_d   = seq_err_q;
        proto_err_d = proto_err_q;

        if (rd_en)                inflight_d = 1'b1;
        else if (bus.rdata_valid) inflight_d = 1'b0;

        if (bus.rdata_valid) begin
            cnt_d    = cnt_q + cnt_w'(1);
            // Always resync so a single bad word raises one event, not a cascade.
            expect_d = bus.rdata + wd'(1);
            first_d  = 1'b0;
            if (!first_q && (bus.rdata != expect_q)) seq_err_d = 1'b1;
            if (!inflight_q)                          proto_err_d = 1'b1;
        end
        if (ovf) proto_err_d = 1'b1;
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            first_q     <= 1'b1;
            expect_q    <= '0;
            cnt_q       <= '0;
            seq_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            first_q     <= first_d;
            expect_q    <= expect_d;
            cnt_q       <= cnt_d;
            seq_err_q   <= seq_err_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign word_cnt_o  = cnt_q;
    assign seq_err_o   = seq_err_q;
    assign proto_err_o = proto_err_q;

endmodule
